rob_multi_commit: RTL
=====================

# rob_multi_commit

Parametrised reorder buffer, successor to the single-commit ROB. It sits between the decoder (issue), the execution units and LSB (write-back), and the register file (commit). Depth, write-back port count and commit width are all configurable. It retires up to COMMIT_W entries per cycle in order, and raises a registered flush with a redirect PC when a mispredicted branch retires.

## Interface
- DEPTH, 16, entry count; power of two, ≥4
- IDX_W, $clog2(DEPTH), entry index width
- NUM_WB, 3, write-back ports (ALU, LSB, spare)
- COMMIT_W, 2, max retirements per cycle (1 or 2)
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global enable; low freezes all state
- iss_valid  in  1  issue request
- iss_data_rdy / iss_type / iss_value / iss_rd / iss_addr  in  1/2/32/5/32  issue payload; iss_value = result (RG) or redirect target (BR)
- iss_idx  out  IDX_W  tail index given to the issuing instruction
- full  out  1  count == DEPTH
- count  out  IDX_W+1  occupancy
- q_idx1, q_idx2  in  IDX_W  operand query indices
- q_rdy1/q_val1, q_rdy2/q_val2  out  1/32  query results
- wb_valid  in  NUM_WB  per-port write-back strobe
- wb_idx / wb_value / wb_mispred  in  NUM_WB×IDX_W / NUM_WB×32 / NUM_WB  flattened, port 0 in LSBs
- head_idx, head_valid  out  IDX_W/1  head info to LSB
- st_ok  in  1  LSB has performed the store at head
- cm_valid  out  COMMIT_W  register-file commit strobes
- cm_rd / cm_value / cm_idx  out  COMMIT_W×5 / ×32 / ×IDX_W  commit payloads
- flush  out  1  pipeline clear
- flush_pc  out  32  redirect target

## Operation
- Entry fields: busy, ready, type, value, rd, mispred, addr. head, tail and count are registered. full and empty derive from count, never from a pointer compare.
- Issue (rdy_in && iss_valid && !full && !flush): write the entry at tail, set busy, tail+1 wrapping mod DEPTH. Issue while full is ignored; no state change.
- Write-back, per port with wb_valid: set ready; store value unless type is BR; for BR store mispred.
  - Port to a non-busy entry: ignored.
  - Two ports to the same index: lowest port number wins.
- Commit slot k may retire only if all of the following hold:
  - slots <k retire this cycle;
  - entry head+k is busy and ready;
  - type ST: k==0 and st_ok;
  - no earlier slot this cycle is a mispredicted BR.
- Retired RG drives cm_valid[k] with its rd, value and index. ST and BR drive no cm_valid.
- Retired BR with mispred: on the next edge flush←1 and flush_pc←value.
- count_next = count + issued − retired.
- Flush cycle (flush && rdy_in): clear all busy/ready, head=tail=count=0, flush←0. Issue, write-back and commit are ignored in this cycle.
- Query: if the entry is ready, return its stored value. Otherwise take the lowest matching wb port this cycle (same-cycle bypass). Otherwise q_rdy=0 and q_val=0.
- rdy_in low: hold all state; cm_valid forced 0.

## Timing
- Reset (async assert, sync release): all entries cleared, head=tail=count=0. Every output is 0, including full, flush, flush_pc and cm_valid.
- Issue at edge N: entry visible to query and commit from cycle N+1.
- Write-back at edge N: q_rdy high in cycle N via bypass. Entry commit-eligible in N+1.
- Commit outputs are combinational from registered state; head advances at the same edge the register file samples them.
- Mispredicted BR retired at edge N: flush high for exactly cycle N+1; ROB empty from N+2.
- Same-cycle commit does not free space for issue: full is based on registered count.
- Reset asserted mid-flush or mid-commit: immediate clear; no commit strobes leak.

## Structure
- Package rob_pkg holds:
  - ROB_RG=2'd0, ROB_ST=2'd1, ROB_BR=2'd2;
  - TYPE_W=2;
  - the entry struct (busy, ready, type, value, rd, mispred, addr).
- Sub-module rob_commit_sel: combinational. Takes COMMIT_W head-window entries plus st_ok; produces the retire mask and the flush request.

## Test plan
- Reset, issue 16 RG entries (DEPTH=16) -> full=1, count=16; 17th issue ignored, iss_idx stays 0.
- Issue RG idx0, idx1; wb ports 0 and 1 write 0x11 and 0x22 in the same cycle -> next cycle cm_valid=2'b11, cm_value={0x22,0x11}, count drops by 2.
- Head ST then RG, both ready, st_ok=0 -> nothing retires; st_ok=1 -> only the ST retires that cycle, RG retires the next cycle.
- Issue BR(value=0x1000) then RG; wb BR mispred=1 and RG ready -> BR retires alone; next cycle flush=1, flush_pc=0x1000; then count=0, iss_idx=0.
- q_idx1=5 with entry 5 not ready while wb port 2 writes idx 5 value 0xABCD -> q_rdy1=1, q_val1=0xABCD in the same cycle.
- Wrap and stall: cycle 40 issue/commit pairs -> head/tail wrap, no loss. Hold rdy_in=0 for 3 cycles mid-stream -> cm_valid=0 and state unchanged. Drop rst_n_in mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/rob_pkg.sv
// rob_pkg: shared types and constants for the multi-commit reorder buffer
package rob_pkg;
  localparam int TYPE_W = 2;
  localparam logic [TYPE_W-1:0] ROB_RG = 2'd0;
  localparam logic [TYPE_W-1:0] ROB_ST = 2'd1;
  localparam logic [TYPE_W-1:0] ROB_BR = 2'd2;
  typedef struct packed {
    logic busy;
    logic ready;
    logic [TYPE_W-1:0] typ;
    logic [31:0] value;
    logic [4:0] rd;
    logic mispred;
    logic [31:0] addr;
  } rob_entry_t;
endpackage

// File: rtl/rob_multi_commit_if.sv
// rob_multi_commit_if: issue/query/write-back/commit/flush bundle; master = core side, slave = ROB
interface rob_multi_commit_if
  import rob_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int NUM_WB = 3,
  parameter int COMMIT_W = 2,
  parameter int IDX_W = $clog2(DEPTH)
);
  logic rdy_in;
  logic iss_valid;
  logic iss_data_rdy;
  logic [TYPE_W-1:0] iss_type;
  logic [31:0] iss_value;
  logic [4:0] iss_rd;
  logic [31:0] iss_addr;
  logic [IDX_W-1:0] iss_idx;
  logic full;
  logic [IDX_W:0] count;
  logic [IDX_W-1:0] q_idx1, q_idx2;
  logic q_rdy1, q_rdy2;
  logic [31:0] q_val1, q_val2;
  logic [NUM_WB-1:0] wb_valid;
  logic [NUM_WB*IDX_W-1:0] wb_idx;
  logic [NUM_WB*32-1:0] wb_value;
  logic [NUM_WB-1:0] wb_mispred;
  logic [IDX_W-1:0] head_idx;
  logic head_valid;
  logic st_ok;
  logic [COMMIT_W-1:0] cm_valid;
  logic [COMMIT_W*5-1:0] cm_rd;
  logic [COMMIT_W*32-1:0] cm_value;
  logic [COMMIT_W*IDX_W-1:0] cm_idx;
  logic flush;
  logic [31:0] flush_pc;
  modport master (
    output rdy_in, iss_valid, iss_data_rdy, iss_type, iss_value, iss_rd, iss_addr,
    output q_idx1, q_idx2, wb_valid, wb_idx, wb_value, wb_mispred, st_ok,
    input iss_idx, full, count, q_rdy1, q_val1, q_rdy2, q_val2,
    input head_idx, head_valid, cm_valid, cm_rd, cm_value, cm_idx, flush, flush_pc
  );
  modport slave (
    input rdy_in, iss_valid, iss_data_rdy, iss_type, iss_value, iss_rd, iss_addr,
    input q_idx1, q_idx2, wb_valid, wb_idx, wb_value, wb_mispred, st_ok,
    output iss_idx, full, count, q_rdy1, q_val1, q_rdy2, q_val2,
    output head_idx, head_valid, cm_valid, cm_rd, cm_value, cm_idx, flush, flush_pc
  );
endinterface

// File: rtl/rob_commit_sel.sv
// rob_commit_sel: in-order retire mask and flush request over the head window (win[0] = head)
module rob_commit_sel
  import rob_pkg::*;
#(
  parameter int COMMIT_W = 2
) (
  input  rob_entry_t win [COMMIT_W],
  input  logic st_ok,
  output logic [COMMIT_W-1:0] retire,
  output logic flush_req,
  output logic [31:0] flush_pc
);
  always_comb begin
    logic go;
    go = 1'b1;
    retire = '0;
    flush_req = 1'b0;
    flush_pc = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      retire[k] = go && win[k].busy && win[k].ready && (win[k].typ != ROB_ST || (k == 0 && st_ok));
      if (retire[k] && win[k].typ == ROB_BR && win[k].mispred) begin
        flush_req = 1'b1;
        flush_pc = win[k].value;
      end
      // a mispredicted branch or a store closes the group: st_ok only speaks for the head store
      go = retire[k] && !(win[k].typ == ROB_BR && win[k].mispred) && win[k].typ != ROB_ST;
    end
  end
endmodule

// File: rtl/rob_multi_commit.sv
// rob_multi_commit: reorder buffer with NUM_WB write-back ports, COMMIT_W-wide in-order commit, registered flush
module rob_multi_commit
  import rob_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int NUM_WB = 3,
  parameter int COMMIT_W = 2,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input logic clk_in,
  input logic rst_n_in,
  rob_multi_commit_if.slave bus
);
  rob_entry_t ent [DEPTH];
  rob_entry_t win [COMMIT_W];
  logic [IDX_W-1:0] win_idx [COMMIT_W];
  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0] count, n_ret;
  logic flush_q;
  logic [31:0] flush_pc_q, req_pc;
  logic [COMMIT_W-1:0] sel_mask, retire;
  logic flush_req, active, issue;
  assign active = bus.rdy_in && !flush_q;
  assign issue = active && bus.iss_valid && !bus.full;
  assign retire = active ? sel_mask : '0;
  assign bus.iss_idx = tail;
  assign bus.full = count == (IDX_W+1)'(DEPTH);
  assign bus.count = count;
  assign bus.head_idx = head;
  assign bus.head_valid = ent[head].busy;
  assign bus.flush = flush_q;
  assign bus.flush_pc = flush_pc_q;
  always_comb begin
    n_ret = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      win_idx[k] = head + IDX_W'(k);
      win[k] = ent[win_idx[k]];
      n_ret = n_ret + (IDX_W+1)'(retire[k]);
    end
  end
  rob_commit_sel #(.COMMIT_W(COMMIT_W)) u_sel (
    .win(win),
    .st_ok(bus.st_ok),
    .retire(sel_mask),
    .flush_req(flush_req),
    .flush_pc(req_pc)
  );
  always_comb begin
    bus.cm_valid = '0;
    bus.cm_rd = '0;
    bus.cm_value = '0;
    bus.cm_idx = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      bus.cm_valid[k] = retire[k] && win[k].typ == ROB_RG;
      bus.cm_rd[k*5 +: 5] = bus.cm_valid[k] ? win[k].rd : 5'd0;
      bus.cm_value[k*32 +: 32] = bus.cm_valid[k] ? win[k].value : 32'd0;
      bus.cm_idx[k*IDX_W +: IDX_W] = bus.cm_valid[k] ? win_idx[k] : '0;
    end
  end
  // descending port loop so the lowest matching port is the one left standing
  always_comb begin
    bus.q_rdy1 = ent[bus.q_idx1].ready;
    bus.q_val1 = bus.q_rdy1 ? ent[bus.q_idx1].value : 32'd0;
    bus.q_rdy2 = ent[bus.q_idx2].ready;
    bus.q_val2 = bus.q_rdy2 ? ent[bus.q_idx2].value : 32'd0;
    for (int p = NUM_WB - 1; p >= 0; p--) begin
      if (!ent[bus.q_idx1].ready && bus.wb_valid[p] && bus.wb_idx[p*IDX_W +: IDX_W] == bus.q_idx1) begin
        bus.q_rdy1 = 1'b1;
        bus.q_val1 = bus.wb_value[p*32 +: 32];
      end
      if (!ent[bus.q_idx2].ready && bus.wb_valid[p] && bus.wb_idx[p*IDX_W +: IDX_W] == bus.q_idx2) begin
        bus.q_rdy2 = 1'b1;
        bus.q_val2 = bus.wb_value[p*32 +: 32];
      end
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      flush_q <= 1'b0;
      flush_pc_q <= '0;
    end else if (bus.rdy_in) begin
      if (flush_q) begin
        for (int i = 0; i < DEPTH; i++) begin
          ent[i].busy <= 1'b0;
          ent[i].ready <= 1'b0;
        end
        head <= '0;
        tail <= '0;
        count <= '0;
        flush_q <= 1'b0;
      end else begin
        if (issue)
          ent[tail] <= '{busy: 1'b1, ready: bus.iss_data_rdy, typ: bus.iss_type, value: bus.iss_value,
                         rd: bus.iss_rd, mispred: 1'b0, addr: bus.iss_addr};
        for (int p = NUM_WB - 1; p >= 0; p--) begin
          if (bus.wb_valid[p] && ent[bus.wb_idx[p*IDX_W +: IDX_W]].busy) begin
            ent[bus.wb_idx[p*IDX_W +: IDX_W]].ready <= 1'b1;
            if (ent[bus.wb_idx[p*IDX_W +: IDX_W]].typ == ROB_BR)
              ent[bus.wb_idx[p*IDX_W +: IDX_W]].mispred <= bus.wb_mispred[p];
            else
              ent[bus.wb_idx[p*IDX_W +: IDX_W]].value <= bus.wb_value[p*32 +: 32];
          end
        end
        for (int k = 0; k < COMMIT_W; k++) begin
          if (retire[k]) begin
            ent[win_idx[k]].busy <= 1'b0;
            ent[win_idx[k]].ready <= 1'b0;
          end
        end
        head <= head + n_ret[IDX_W-1:0];
        tail <= tail + IDX_W'(issue);
        count <= count + (IDX_W+1)'(issue) - n_ret;
        flush_q <= flush_req;
        flush_pc_q <= flush_req ? req_pc : flush_pc_q;
      end
    end
  end
endmodule
